// File: rtl/unified_buffer_read_sequencer_pkg.sv
// Shared types and default widths for the unified buffer read sequencer.
// The command struct is sized from the package constants, which match the top-level parameter defaults.
package unified_buffer_read_sequencer_pkg;

  localparam int UB_ADDR_W    = 12;
  localparam int UB_DIM_W     = 8;
  localparam int UB_TILE_LOG2 = 5;
  localparam int UB_TIDX_W    = 3;

  typedef enum logic {
    Y_INNER = 1'b0,
    X_INNER = 1'b1
  } ub_rd_order_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT_W = 2'd1,
    READ   = 2'd2
  } ub_rd_state_e;

  typedef struct packed {
    logic [UB_ADDR_W-1:0]  start_addr;
    logic [UB_DIM_W-2:0]   u_dim1;
    logic [UB_DIM_W-1:0]   v_dim;
    logic [UB_DIM_W-2:0]   iter_dim1;
    ub_rd_order_e          order;
  } ub_rd_cmd_t;

endpackage

// File: rtl/unified_buffer_read_sequencer_walker.sv
// Nested row / x-tile / y-tile counters for one read command.
// The next-state values are exported so the parent can register the matching address.
module ub_tile_walker
  import unified_buffer_read_sequencer_pkg::*;
#(
  parameter int DIM_W  = UB_DIM_W,
  parameter int TIDX_W = UB_TIDX_W
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  input  logic              en_i,
  input  ub_rd_order_e      order_i,
  input  logic [DIM_W-1:0]  v_dim_i,
  input  logic [TIDX_W-1:0] x_max_i,
  input  logic [TIDX_W-1:0] y_max_i,
  output logic [DIM_W-1:0]  row_o,
  output logic [TIDX_W-1:0] x_o,
  output logic [TIDX_W-1:0] y_o,
  output logic [DIM_W-1:0]  row_nxt_o,
  output logic [TIDX_W-1:0] x_nxt_o,
  output logic              last_row_o,
  output logic              x_wrap_o,
  output logic              y_wrap_o,
  output logic              last_o
);

  logic [DIM_W-1:0]  row_q, row_d;
  logic [TIDX_W-1:0] x_q, x_d;
  logic [TIDX_W-1:0] y_q, y_d;

  assign last_row_o = (row_q == (v_dim_i - DIM_W'(1)));
  assign x_wrap_o   = (x_q == x_max_i);
  assign y_wrap_o   = (y_q == y_max_i);
  assign last_o     = last_row_o & x_wrap_o & y_wrap_o;

  always_comb begin
    row_d = row_q;
    x_d   = x_q;
    y_d   = y_q;
    if (clear_i) begin
      row_d = '0;
      x_d   = '0;
      y_d   = '0;
    end else if (en_i) begin
      if (last_row_o) begin
        row_d = '0;
        // The inner tile dimension steps every pass; the outer one only on inner wrap.
        if (order_i == Y_INNER) begin
          if (y_wrap_o) begin
            y_d = '0;
            x_d = x_wrap_o ? '0 : x_q + TIDX_W'(1);
          end else begin
            y_d = y_q + TIDX_W'(1);
          end
        end else begin
          if (x_wrap_o) begin
            x_d = '0;
            y_d = y_wrap_o ? '0 : y_q + TIDX_W'(1);
          end else begin
            x_d = x_q + TIDX_W'(1);
          end
        end
      end else begin
        row_d = row_q + DIM_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      row_q <= '0;
      x_q   <= '0;
      y_q   <= '0;
    end else begin
      row_q <= row_d;
      x_q   <= x_d;
      y_q   <= y_d;
    end
  end

  assign row_o     = row_q;
  assign x_o       = x_q;
  assign y_o       = y_q;
  assign row_nxt_o = row_d;
  assign x_nxt_o   = x_d;

endmodule

// File: rtl/unified_buffer_read_sequencer.sv
// Unified buffer read controller: command intake with a one-entry prefetch slot,
// weight-ready gating, and one registered read address per handshaked beat.
module unified_buffer_read_sequencer
  import unified_buffer_read_sequencer_pkg::*;
#(
  parameter int ADDR_W    = UB_ADDR_W,
  parameter int DIM_W     = UB_DIM_W,
  parameter int TILE_LOG2 = UB_TILE_LOG2,
  parameter int TIDX_W    = UB_TIDX_W
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [ADDR_W-1:0] cmd_start_addr_i,
  input  logic [DIM_W-2:0]  cmd_u_dim1_i,
  input  logic [DIM_W-1:0]  cmd_v_dim_i,
  input  logic [DIM_W-2:0]  cmd_iter_dim1_i,
  input  logic              cmd_order_i,
  input  logic              weights_rdy_i,
  input  logic              rd_ready_i,
  output logic              rd_en_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  output logic [TIDX_W-1:0] tile_x_o,
  output logic [TIDX_W-1:0] tile_y_o,
  output logic              last_row_o,
  output logic              busy_o,
  output logic              done_o
);

  ub_rd_state_e      state_q, state_d;
  ub_rd_cmd_t        active_q, pend_q, in_cmd, new_cmd;
  logic              pend_vld_q, pend_vld_d;
  logic              store_pend, load;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              done_q;

  logic              accept, fire, complete;
  logic [DIM_W-1:0]  row, row_nxt;
  logic [TIDX_W-1:0] x_nxt;
  logic [TIDX_W-1:0] x_max, y_max;
  logic              w_last_row, w_x_wrap, w_y_wrap, w_last;

  always_comb begin
    in_cmd            = '0;
    in_cmd.start_addr = cmd_start_addr_i;
    in_cmd.u_dim1     = cmd_u_dim1_i;
    in_cmd.v_dim      = cmd_v_dim_i;
    in_cmd.iter_dim1  = cmd_iter_dim1_i;
    in_cmd.order      = ub_rd_order_e'(cmd_order_i);
  end

  assign x_max = TIDX_W'(active_q.iter_dim1 >> TILE_LOG2);
  assign y_max = TIDX_W'(active_q.u_dim1 >> TILE_LOG2);

  assign rd_en_o     = (state_q == READ);
  assign busy_o      = (state_q != IDLE);
  assign cmd_ready_o = (state_q == IDLE) | ~pend_vld_q;
  assign accept      = cmd_valid_i & cmd_ready_o;
  assign fire        = rd_en_o & rd_ready_i;
  // A zero-row command finishes on its first WAIT_W cycle without touching the read port.
  assign complete    = (fire & w_last) |
                       ((state_q == WAIT_W) && (active_q.v_dim == '0));

  always_comb begin
    state_d    = state_q;
    pend_vld_d = pend_vld_q;
    store_pend = 1'b0;
    load       = 1'b0;
    new_cmd    = in_cmd;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          load    = 1'b1;
          state_d = WAIT_W;
        end
      end
      WAIT_W: begin
        if (weights_rdy_i) state_d = READ;
      end
      READ: ;
      default: state_d = IDLE;
    endcase
    if (complete) begin
      if (pend_vld_q) begin
        load       = 1'b1;
        new_cmd    = pend_q;
        pend_vld_d = 1'b0;
      end else if (accept) begin
        load = 1'b1;
      end
      if (load) begin
        state_d = (weights_rdy_i && (new_cmd.v_dim != '0)) ? READ : WAIT_W;
      end else begin
        state_d = IDLE;
      end
    end else if ((state_q != IDLE) && accept) begin
      store_pend = 1'b1;
      pend_vld_d = 1'b1;
    end
  end

  // Address tracks the walker's next position so rd_addr_o is a plain flop output.
  always_comb begin
    addr_d = addr_q;
    if (load) begin
      addr_d = new_cmd.start_addr;
    end else if (fire) begin
      addr_d = active_q.start_addr
             + ADDR_W'(x_nxt) * ADDR_W'(active_q.v_dim)
             + ADDR_W'(row_nxt);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      pend_vld_q <= 1'b0;
      addr_q     <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_vld_q <= pend_vld_d;
      addr_q     <= addr_d;
      done_q     <= complete;
    end
  end

  always_ff @(posedge clk_i) begin
    if (load)       active_q <= new_cmd;
    if (store_pend) pend_q   <= in_cmd;
  end

  ub_tile_walker #(
    .DIM_W  (DIM_W),
    .TIDX_W (TIDX_W)
  ) u_walker (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .clear_i    (load),
    .en_i       (fire),
    .order_i    (active_q.order),
    .v_dim_i    (active_q.v_dim),
    .x_max_i    (x_max),
    .y_max_i    (y_max),
    .row_o      (row),
    .x_o        (tile_x_o),
    .y_o        (tile_y_o),
    .row_nxt_o  (row_nxt),
    .x_nxt_o    (x_nxt),
    .last_row_o (w_last_row),
    .x_wrap_o   (w_x_wrap),
    .y_wrap_o   (w_y_wrap),
    .last_o     (w_last)
  );

  assign rd_addr_o  = addr_q;
  assign last_row_o = rd_en_o & w_last_row;
  assign done_o     = done_q;

endmodule

// File: tb/tb_unified_buffer_read_sequencer.sv
// Directed bench for the unified buffer read sequencer with hand-computed beat tables.
module tb_unified_buffer_read_sequencer;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic [11:0] cmd_start_addr_i;
  logic [6:0]  cmd_u_dim1_i;
  logic [7:0]  cmd_v_dim_i;
  logic [6:0]  cmd_iter_dim1_i;
  logic        cmd_order_i;
  logic        weights_rdy_i;
  logic        rd_ready_i;
  logic        rd_en_o;
  logic [11:0] rd_addr_o;
  logic [2:0]  tile_x_o;
  logic [2:0]  tile_y_o;
  logic        last_row_o;
  logic        busy_o;
  logic        done_o;

  int tests = 0;
  int fails = 0;

  logic [11:0] ea [8];
  logic [2:0]  ex [8];
  logic [2:0]  ey [8];
  logic        el [8];

  unified_buffer_read_sequencer dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .cmd_valid_i      (cmd_valid_i),
    .cmd_ready_o      (cmd_ready_o),
    .cmd_start_addr_i (cmd_start_addr_i),
    .cmd_u_dim1_i     (cmd_u_dim1_i),
    .cmd_v_dim_i      (cmd_v_dim_i),
    .cmd_iter_dim1_i  (cmd_iter_dim1_i),
    .cmd_order_i      (cmd_order_i),
    .weights_rdy_i    (weights_rdy_i),
    .rd_ready_i       (rd_ready_i),
    .rd_en_o          (rd_en_o),
    .rd_addr_o        (rd_addr_o),
    .tile_x_o         (tile_x_o),
    .tile_y_o         (tile_y_o),
    .last_row_o       (last_row_o),
    .busy_o           (busy_o),
    .done_o           (done_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_cmd(input logic [11:0] s, input logic [6:0] u, input logic [7:0] v,
                         input logic [6:0] it, input logic ord);
    cmd_start_addr_i = s;
    cmd_u_dim1_i     = u;
    cmd_v_dim_i      = v;
    cmd_iter_dim1_i  = it;
    cmd_order_i      = ord;
  endtask

  task automatic send(input logic [11:0] s, input logic [6:0] u, input logic [7:0] v,
                      input logic [6:0] it, input logic ord);
    set_cmd(s, u, v, it, ord);
    cmd_valid_i = 1'b1;
    step();
    cmd_valid_i = 1'b0;
  endtask

  task automatic beat(input string tag, input int i);
    chk($sformatf("%s_en%0d", tag, i), rd_en_o, 1);
    chk($sformatf("%s_addr%0d", tag, i), rd_addr_o, ea[i]);
    chk($sformatf("%s_xyl%0d", tag, i), {tile_x_o, tile_y_o, last_row_o}, {ex[i], ey[i], el[i]});
  endtask

  task automatic load_case1();
    ea = '{12'h100, 12'h101, 12'h102, 12'h103, 12'h100, 12'h101, 12'h102, 12'h103};
    ex = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
    ey = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd1, 3'd1};
    el = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
  endtask

  initial begin
    int nb;
    rst_ni        = 1'b0;
    cmd_valid_i   = 1'b0;
    set_cmd(12'h0, 7'd0, 8'd0, 7'd0, 1'b0);
    weights_rdy_i = 1'b1;
    rd_ready_i    = 1'b1;
    step();
    step();
    chk("rst_outs", {rd_en_o, rd_addr_o, tile_x_o, tile_y_o, last_row_o, busy_o, done_o}, 0);
    chk("rst_ready", cmd_ready_o, 1);
    rst_ni = 1'b1;
    step();

    // Single command, Y_INNER
    load_case1();
    send(12'h100, 7'd63, 8'd4, 7'd31, 1'b0);
    chk("t1_wait", {busy_o, rd_en_o, done_o}, 3'b100);
    step();
    for (int i = 0; i < 8; i++) begin
      beat("t1", i);
      step();
    end
    chk("t1_done", {rd_en_o, done_o}, 2'b01);
    step();
    chk("t1_idle", {busy_o, done_o, cmd_ready_o}, 3'b001);

    // X_INNER, weights arrive late
    ea = '{12'h0, 12'h1, 12'h2, 12'h3, 12'h4, 12'h5, 12'h0, 12'h0};
    ex = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd2, 3'd2, 3'd0, 3'd0};
    ey = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
    el = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    weights_rdy_i = 1'b0;
    send(12'h000, 7'd31, 8'd2, 7'd95, 1'b1);
    chk("t2_wait0", {busy_o, rd_en_o}, 2'b10);
    step();
    chk("t2_wait1", {busy_o, rd_en_o}, 2'b10);
    weights_rdy_i = 1'b1;
    step();
    for (int i = 0; i < 6; i++) begin
      beat("t2", i);
      step();
    end
    chk("t2_done", {rd_en_o, done_o}, 2'b01);
    step();
    chk("t2_idle", {busy_o, done_o}, 2'b00);

    // Backpressure 1,0,0,1
    load_case1();
    send(12'h100, 7'd63, 8'd4, 7'd31, 1'b0);
    step();
    nb = 0;
    for (int c = 0; c < 64 && nb < 8; c++) begin
      rd_ready_i = ((c % 4) == 0) || ((c % 4) == 3);
      beat("t3", nb);
      step();
      if (rd_ready_i) nb++;
    end
    rd_ready_i = 1'b1;
    chk("t3_fires", nb, 8);
    chk("t3_done", {rd_en_o, done_o}, 2'b01);
    step();

    // Back-to-back via pending slot
    load_case1();
    send(12'h100, 7'd63, 8'd4, 7'd31, 1'b0);
    step();
    for (int i = 0; i < 8; i++) begin
      beat("t4", i);
      if (i == 2) begin
        set_cmd(12'h200, 7'd0, 8'd1, 7'd0, 1'b0);
        cmd_valid_i = 1'b1;
        chk("t4_ready_before", cmd_ready_o, 1);
      end
      step();
      if (i == 2) begin
        cmd_valid_i = 1'b0;
        chk("t4_slot_full", cmd_ready_o, 0);
      end
    end
    chk("t4_b2b_beat", {rd_en_o, rd_addr_o, last_row_o}, {1'b1, 12'h200, 1'b1});
    chk("t4_done1", done_o, 1);
    chk("t4_slot_free", cmd_ready_o, 1);
    step();
    chk("t4_done2", {rd_en_o, done_o}, 2'b01);
    step();
    chk("t4_idle", {busy_o, done_o}, 2'b00);

    // V=0: done two cycles after accept, weights not needed
    weights_rdy_i = 1'b0;
    send(12'h300, 7'd0, 8'd0, 7'd0, 1'b0);
    chk("t5_c1", {busy_o, rd_en_o, done_o}, 3'b100);
    step();
    chk("t5_c2", {rd_en_o, done_o}, 2'b01);
    step();
    chk("t5_idle", {busy_o, done_o, cmd_ready_o}, 3'b001);
    weights_rdy_i = 1'b1;

    // Address wrap at top of buffer
    ea = '{12'hFFE, 12'hFFF, 12'h000, 12'h001, 12'h0, 12'h0, 12'h0, 12'h0};
    ex = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
    ey = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
    el = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    send(12'hFFE, 7'd0, 8'd4, 7'd0, 1'b0);
    step();
    for (int i = 0; i < 4; i++) begin
      beat("t6", i);
      step();
    end
    chk("t6_done", {rd_en_o, done_o}, 2'b01);
    step();

    // Async reset mid-READ with the pending slot full
    load_case1();
    send(12'h100, 7'd63, 8'd4, 7'd31, 1'b0);
    step();
    for (int i = 0; i < 7; i++) begin
      if (i == 1) begin
        set_cmd(12'h200, 7'd0, 8'd1, 7'd0, 1'b0);
        cmd_valid_i = 1'b1;
      end
      step();
      if (i == 1) begin
        cmd_valid_i = 1'b0;
        chk("t7_slot_full", cmd_ready_o, 0);
      end
    end
    beat("t7", 7);
    rst_ni = 1'b0;
    #1;
    chk("t7_rst_outs", {rd_en_o, rd_addr_o, tile_x_o, tile_y_o, last_row_o, busy_o, done_o}, 0);
    chk("t7_rst_ready", cmd_ready_o, 1);
    step();
    rst_ni = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("t7_post%0d", k), {rd_en_o, busy_o, done_o, cmd_ready_o}, 4'b0001);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
